// File: rtl/jk_mod_counter_pkg.sv
// Shared definitions for the JK-based modulo counter.
//   JK_* localparams : {J,K} encodings understood by jk_cell
//   jk_excite()      : returns the {J,K} pair that moves one cell from its
//                      current value to the requested next value without
//                      ever using the toggle encoding.
package jk_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // J sets a bit that is 0 and must become 1; K clears a bit that is 1 and
  // must become 0. A bit that keeps its value gets JK_HOLD. Because J needs
  // q_bit=0 and K needs q_bit=1, the pair can never be JK_TGL.
  function automatic logic [1:0] jk_excite(input logic q_bit, input logic nxt_bit);
    return {(~q_bit) & nxt_bit, q_bit & (~nxt_bit)};
  endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control and observation bundle of the JK modulo counter.
//   en, up_dn, load, load_val : driven by the master (controller)
//   q, tc, wrap               : count, terminal count, wrap pulse
//   j_vec, k_vec              : J/K values presented to the cells (debug)
// There is no valid/ready handshake: every control input is sampled on each
// rising clk edge, and outputs are valid for the whole cycle that follows.
interface jk_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;

  modport master (
    output en, up_dn, load, load_val,
    input  q, tc, wrap, j_vec, k_vec
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output q, tc, wrap, j_vec, k_vec
  );
endinterface

// File: rtl/jk_mod_counter_jk_cell.sv
// Single JK flip-flop with asynchronous active-low clear.
//   clk   : rising-edge clock
//   rst_n : async active-low clear (q -> 0)
//   j, k  : 00 hold, 01 clear, 10 set, 11 toggle
//   q     : stored bit
//   qbar  : complement of q
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD: q <= q;
        JK_CLR:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TGL:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// Synchronous modulo-MODULUS up/down counter built from WIDTH JK cells.
//   clk        : rising-edge clock
//   rst_n      : async active-low reset (q=0, wrap=0 immediately)
//   bus.en     : count enable
//   bus.up_dn  : 1 = up, 0 = down
//   bus.load   : synchronous load, wins over en; out-of-range values saturate
//   bus.load_val : value to load
//   bus.q      : current count (cell outputs)
//   bus.tc     : combinational terminal count in the current direction
//   bus.wrap   : registered one-cycle pulse after a cycle with tc=1
//   bus.j_vec / bus.k_vec : J/K inputs driven into the cells this cycle
// Every cycle the top computes the desired next count, turns it into per-bit
// J/K excitation, and lets the cell array realise it on the next edge.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  jk_mod_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic             at_max;
  logic             at_zero;
  logic             tc;
  logic             wrap;

  assign at_max  = (q == MAX_CNT);
  // All complemented cell outputs high means the count is zero.
  assign at_zero = &qbar;

  // Next-count selection. Load saturates at MAX_CNT; counting wraps at the
  // modulus boundaries. With MODULUS == 2**WIDTH the explicit wrap coincides
  // with natural WIDTH-bit overflow.
  always_comb begin
    nxt = q;
    if (bus.load) begin
      nxt = (bus.load_val > MAX_CNT) ? MAX_CNT : bus.load_val;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        nxt = at_max ? '0 : q + WIDTH'(1);
      end else begin
        nxt = at_zero ? MAX_CNT : q - WIDTH'(1);
      end
    end
  end

  // Per-bit excitation and the JK cell array.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic [1:0] jk;
    assign jk       = jk_excite(q[i], nxt[i]);
    assign j_vec[i] = jk[1];
    assign k_vec[i] = jk[0];

    jk_cell u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .j    (j_vec[i]),
      .k    (k_vec[i]),
      .q    (q[i]),
      .qbar (qbar[i])
    );
  end

  // Terminal count only when actually counting; load suppresses it.
  assign tc = bus.en & ~bus.load & (bus.up_dn ? at_max : at_zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tc;
    end
  end

  assign bus.q     = q;
  assign bus.tc    = tc;
  assign bus.wrap  = wrap;
  assign bus.j_vec = j_vec;
  assign bus.k_vec = k_vec;

endmodule

// File: tb/tb_jk_mod_counter.sv
module tb_jk_mod_counter;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic clk;
  logic rst_n;

  jk_mod_counter_if #(.WIDTH(W)) bus ();

  jk_mod_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_w_q[$];

  int           m_q;           // reference count
  logic [W-1:0] last_j;
  logic [W-1:0] last_k;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus. Checks combinational outputs against the reference
  // model before the edge, pushes expected q/wrap, then pops and compares
  // after the edge. Called #1 after a rising edge (or before the first one).
  task automatic step(input logic e, input logic u, input logic l, input logic [W-1:0] lv);
    int           nxt;
    logic         m_tc;
    logic [W-1:0] nv;
    logic [W-1:0] ej;
    logic [W-1:0] ek;
    logic [W-1:0] q_pre;
    logic [W-1:0] got_q;
    logic         got_w;

    bus.en = e; bus.up_dn = u; bus.load = l; bus.load_val = lv;

    if (l)      nxt = (int'(lv) > MOD - 1) ? MOD - 1 : int'(lv);
    else if (e) nxt = u ? (m_q + 1) % MOD : (m_q + MOD - 1) % MOD;
    else        nxt = m_q;
    m_tc = e && !l && (u ? (m_q == MOD - 1) : (m_q == 0));

    nv = W'(nxt);
    ej = ~W'(m_q) & nv;
    ek = W'(m_q) & ~nv;

    #1;
    q_pre  = bus.q;
    last_j = bus.j_vec;
    last_k = bus.k_vec;
    chk("tc", W'(bus.tc), W'(m_tc));
    chk("j_vec", bus.j_vec, ej);
    chk("k_vec", bus.k_vec, ek);
    chk("j_and_k", bus.j_vec & bus.k_vec, '0);

    exp_q.push_back(nv);
    exp_w_q.push_back(m_tc);

    @(posedge clk);
    #1;
    total++;
    if (exp_q.size() == 0 || exp_w_q.size() == 0) begin
      bad++;
      $error("FAIL sb_empty: got size %0d want 1", exp_q.size());
    end else begin
      got_q = exp_q.pop_front();
      got_w = exp_w_q.pop_front();
      total--;
      chk("q", bus.q, got_q);
      chk("wrap", W'(bus.wrap), W'(got_w));
    end
    chk("jk_law", bus.q, (q_pre & ~last_k) | last_j);
    m_q = nxt;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    bus.en = 1'b0; bus.up_dn = 1'b1; bus.load = 1'b0; bus.load_val = '0;
    m_q = 0;
    #12;
    chk("rst_q", bus.q, '0);
    chk("rst_wrap", W'(bus.wrap), '0);
    rst_n = 1'b1;

    // Up wrap: 0..9,0,1 with tc/wrap from the model
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      chk("up_seq", bus.q, W'((i + 1) % MOD));
      if (i == 9) chk("up_wrap_pulse", W'(bus.wrap), W'(1));
    end

    // Async reset mid-count at q=7, between edges
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, '0);
    chk("pre_rst_q7", bus.q, W'(7));
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_q", bus.q, '0);
    chk("async_rst_wrap", W'(bus.wrap), '0);
    m_q = 0;
    #2;
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, '0);
    chk("resume_q1", bus.q, W'(1));

    // Down wrap from 0
    step(1'b0, 1'b0, 1'b1, W'(0));
    chk("load0", bus.q, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("down_wrap_q9", bus.q, W'(9));
    chk("down_wrap_pulse", W'(bus.wrap), W'(1));
    step(1'b1, 1'b0, 1'b0, '0);
    chk("down_q8", bus.q, W'(8));
    chk("down_wrap_gone", W'(bus.wrap), '0);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("down_q7", bus.q, W'(7));

    // Load with en, then saturated load
    step(1'b1, 1'b1, 1'b1, W'(6));
    chk("load6", bus.q, W'(6));
    chk("load6_wrap", W'(bus.wrap), '0);
    step(1'b1, 1'b1, 1'b1, W'(13));
    chk("load13_sat", bus.q, W'(9));
    // load at q=9 while counting up: tc must stay 0, no wrap
    step(1'b1, 1'b1, 1'b1, W'(2));
    chk("load_at_max_wrap", W'(bus.wrap), '0);

    // Hold at 4
    step(1'b0, 1'b0, 1'b1, W'(4));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, i[0], 1'b0, '0);
      chk("hold_q4", bus.q, W'(4));
      chk("hold_j", last_j, '0);
      chk("hold_k", last_k, '0);
    end

    // Direction flip every cycle
    step(1'b1, 1'b1, 1'b0, '0); chk("flip_5a", bus.q, W'(5));
    step(1'b1, 1'b0, 1'b0, '0); chk("flip_4a", bus.q, W'(4));
    step(1'b1, 1'b1, 1'b0, '0); chk("flip_5b", bus.q, W'(5));
    step(1'b1, 1'b0, 1'b0, '0); chk("flip_4b", bus.q, W'(4));

    // 7 -> 8 excitation
    step(1'b0, 1'b0, 1'b1, W'(7));
    step(1'b1, 1'b1, 1'b0, '0);
    chk("q8", bus.q, W'(8));
    chk("j_7to8", last_j, 4'b1000);
    chk("k_7to8", last_k, 4'b0111);

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), W'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
